// File: rtl/knn_pkg.sv
// Shared definitions for the k-nearest-neighbour result reader.
// Optional build macro: KNN_VOTE_EN (adds the majority-vote stage).
package knn_pkg;

  // Reader states; ST_VOTE is only entered when KNN_VOTE_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_VOTE = 2'd2,
    ST_DONE = 2'd3
  } knn_state_e;

  // Number of sorted entries per result; fixed at 4 in this revision.
  localparam int KNN_K = 4;

  // Width of a match count, able to hold 0..KNN_K.
  localparam int KNN_CNT_W = $clog2(KNN_K + 1);

  // Distance value the sorter uses for an empty slot.
  localparam logic [31:0] KNN_SENTINEL = 32'hFFFF_FFFF;

endpackage

// File: rtl/knn_vote_cnt.sv
// Counts how many of the K snapshot labels equal one candidate label.
// Purely combinational.
module knn_vote_cnt
  import knn_pkg::*;
#(
  parameter int LABEL_W = 8
) (
  input  logic [LABEL_W-1:0]              label,
  input  logic [KNN_K-1:0][LABEL_W-1:0]   labels,
  output logic [KNN_CNT_W-1:0]            count
);

  // Sum of equality matches across all K entries.
  always_comb begin
    count = '0;
    for (int i = 0; i < KNN_K; i++) begin
      if (labels[i] == label) begin
        count = count + KNN_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/knn_result_reader.sv
// Snapshots the K sorted distance/label pairs of the sorter on start and
// drains them as K beats over a valid/ready stream, nearest first.
// Optional build macro: KNN_VOTE_EN adds a K-cycle majority vote after the
// drain and exposes VOTE_LABEL / VOTE_VALID.
//
// Handshake: out_valid is high for every cycle in SEND and the beat fields
// (OUT_DATA, OUT_LABEL, OUT_IDX, OUT_LAST) stay constant until the cycle in
// which out_valid and out_ready are both high; that cycle transfers the beat
// and the next cycle presents the following index. There is no timeout.
module knn_result_reader
  import knn_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 8,
  parameter int K       = KNN_K
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  DATA0_IN,
  input  logic [DATA_W-1:0]  DATA1_IN,
  input  logic [DATA_W-1:0]  DATA2_IN,
  input  logic [DATA_W-1:0]  DATA3_IN,
  input  logic [LABEL_W-1:0] LABEL0_IN,
  input  logic [LABEL_W-1:0] LABEL1_IN,
  input  logic [LABEL_W-1:0] LABEL2_IN,
  input  logic [LABEL_W-1:0] LABEL3_IN,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  OUT_DATA,
  output logic [LABEL_W-1:0] OUT_LABEL,
  output logic [1:0]         OUT_IDX,
  output logic               OUT_LAST,
  output logic               busy,
  output knn_state_e         state_dbg,
  output logic               done
`ifdef KNN_VOTE_EN
  ,
  output logic [LABEL_W-1:0] VOTE_LABEL,
  output logic               VOTE_VALID
`endif
);

  localparam logic [1:0] LAST_IDX = 2'(K - 1);

  knn_state_e state;
  knn_state_e state_nxt;

  logic [KNN_K-1:0][DATA_W-1:0]  snap_data;
  logic [KNN_K-1:0][LABEL_W-1:0] snap_label;
  logic [1:0]                    idx;

  logic accept_start;
  logic beat_xfer;

  assign accept_start = (state == ST_IDLE) && start;
  assign beat_xfer    = (state == ST_SEND) && out_ready;

`ifdef KNN_VOTE_EN
  logic [1:0]           vote_j;
  logic [LABEL_W-1:0]   cand_label;
  logic [KNN_CNT_W-1:0] cand_cnt;
  logic [KNN_CNT_W-1:0] best_cnt;
  logic [LABEL_W-1:0]   best_label;
  logic                 cand_wins;
  logic [LABEL_W-1:0]   best_label_nxt;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    OUT_LAST  = 1'b0;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        OUT_LAST  = (idx == LAST_IDX);
        if (out_ready && (idx == LAST_IDX)) begin
`ifdef KNN_VOTE_EN
          state_nxt = ST_VOTE;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef KNN_VOTE_EN
      ST_VOTE: begin
        if (vote_j == LAST_IDX) begin
          state_nxt = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Snapshot capture on an accepted start; held until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_data  <= '0;
      snap_label <= '0;
    end else if (accept_start) begin
      snap_data[0]  <= DATA0_IN;
      snap_data[1]  <= DATA1_IN;
      snap_data[2]  <= DATA2_IN;
      snap_data[3]  <= DATA3_IN;
      snap_label[0] <= LABEL0_IN;
      snap_label[1] <= LABEL1_IN;
      snap_label[2] <= LABEL2_IN;
      snap_label[3] <= LABEL3_IN;
    end
  end

  // Beat index: advances on each transfer and wraps to 0 after the last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= 2'd0;
    end else if (beat_xfer) begin
      idx <= (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
    end
  end

  assign OUT_IDX   = idx;
  assign OUT_DATA  = snap_data[idx];
  assign OUT_LABEL = snap_label[idx];
  assign state_dbg = state;

`ifdef KNN_VOTE_EN
  assign cand_label = snap_label[vote_j];

  knn_vote_cnt #(
    .LABEL_W (LABEL_W)
  ) u_vote_cnt (
    .label  (cand_label),
    .labels (snap_label),
    .count  (cand_cnt)
  );

  // Strictly-greater keeps the earlier (nearer) candidate on a tie.
  assign cand_wins      = (cand_cnt > best_cnt);
  assign best_label_nxt = cand_wins ? cand_label : best_label;

  // Vote scan over the snapshot; the result is published entering DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote_j     <= 2'd0;
      best_cnt   <= '0;
      best_label <= '0;
      VOTE_LABEL <= '0;
      VOTE_VALID <= 1'b0;
    end else if (accept_start) begin
      vote_j     <= 2'd0;
      best_cnt   <= '0;
      best_label <= '0;
      VOTE_VALID <= 1'b0;
    end else if (state == ST_VOTE) begin
      vote_j <= (vote_j == LAST_IDX) ? 2'd0 : vote_j + 2'd1;
      if (cand_wins) begin
        best_cnt   <= cand_cnt;
        best_label <= cand_label;
      end
      if (vote_j == LAST_IDX) begin
        VOTE_LABEL <= best_label_nxt;
        VOTE_VALID <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_knn_result_reader.sv
// Bench for knn_result_reader: queue-based reference model checked every
// cycle, plus directed drains with hand-computed beat values.
module tb_knn_result_reader;
  import knn_pkg::*;

  localparam int DW = 32;
  localparam int LW = 8;
`ifdef KNN_VOTE_EN
  localparam int DLAT = 5;
`else
  localparam int DLAT = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic [DW-1:0] d_in [4];
  logic [LW-1:0] l_in [4];
  logic out_valid, OUT_LAST, busy, done;
  logic [DW-1:0] OUT_DATA;
  logic [LW-1:0] OUT_LABEL;
  logic [1:0] OUT_IDX;
  knn_state_e state_dbg;
`ifdef KNN_VOTE_EN
  logic [LW-1:0] VOTE_LABEL;
  logic VOTE_VALID;
`endif

  always #5 clk = ~clk;

  knn_result_reader #(.DATA_W(DW), .LABEL_W(LW), .K(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .DATA0_IN  (d_in[0]),
    .DATA1_IN  (d_in[1]),
    .DATA2_IN  (d_in[2]),
    .DATA3_IN  (d_in[3]),
    .LABEL0_IN (l_in[0]),
    .LABEL1_IN (l_in[1]),
    .LABEL2_IN (l_in[2]),
    .LABEL3_IN (l_in[3]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT_DATA  (OUT_DATA),
    .OUT_LABEL (OUT_LABEL),
    .OUT_IDX   (OUT_IDX),
    .OUT_LAST  (OUT_LAST),
    .busy      (busy),
    .state_dbg (state_dbg),
    .done      (done)
`ifdef KNN_VOTE_EN
    ,
    .VOTE_LABEL(VOTE_LABEL),
    .VOTE_VALID(VOTE_VALID)
`endif
  );

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] vote_of(input logic [LW-1:0] l [4]);
    int best_c;
    logic [LW-1:0] best;
    best_c = 0;
    best   = '0;
    for (int j = 0; j < 4; j++) begin
      int c;
      c = 0;
      for (int i = 0; i < 4; i++) if (l[i] == l[j]) c++;
      if (c > best_c) begin
        best_c = c;
        best   = l[j];
      end
    end
    return best;
  endfunction

  // ---------------- scoreboard / model ----------------
  // Each entry is {data, label, idx} of a beat still owed by the DUT.
  logic [DW+LW+1:0] exp_q[$];
  int done_cd = 0;
  logic exp_vv = 1'b0;
  logic [LW-1:0] exp_vl = '0;
  logic [LW-1:0] pend_vl = '0;

  always @(negedge clk) begin
    logic ev, eb, ed;
    logic [DW+LW+1:0] b;
    if (!rst) begin
      exp_q.delete();
      done_cd = 0;
      exp_vv  = 1'b0;
      exp_vl  = '0;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_busy",  64'(busy),      64'd0);
      chk("rst_done",  64'(done),      64'd0);
      chk("rst_idx",   64'(OUT_IDX),   64'd0);
      chk("rst_last",  64'(OUT_LAST),  64'd0);
`ifdef KNN_VOTE_EN
      chk("rst_vote_valid", 64'(VOTE_VALID), 64'd0);
      chk("rst_vote_label", 64'(VOTE_LABEL), 64'd0);
`endif
    end else begin
      ev = (exp_q.size() > 0);
      eb = ev || (done_cd > 0);
      ed = (done_cd == 1);
      if (ed) begin
        exp_vv = 1'b1;
        exp_vl = pend_vl;
      end
      chk("valid", 64'(out_valid), 64'(ev));
      chk("busy",  64'(busy),      64'(eb));
      chk("done",  64'(done),      64'(ed));
      if (ev) begin
        b = exp_q[0];
        chk("beat_data",  64'(OUT_DATA),  64'(b[DW+LW+1:LW+2]));
        chk("beat_label", 64'(OUT_LABEL), 64'(b[LW+1:2]));
        chk("beat_idx",   64'(OUT_IDX),   64'(b[1:0]));
        chk("beat_last",  64'(OUT_LAST),  64'(b[1:0] == 2'd3));
      end else begin
        chk("idle_idx",  64'(OUT_IDX),  64'd0);
        chk("idle_last", 64'(OUT_LAST), 64'd0);
      end
`ifdef KNN_VOTE_EN
      chk("vote_valid", 64'(VOTE_VALID), 64'(exp_vv));
      if (exp_vv) chk("vote_label", 64'(VOTE_LABEL), 64'(exp_vl));
`endif
      // advance model to the next cycle
      if (done_cd > 0) done_cd--;
      if (ev && out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done_cd = DLAT;
      end
      if (!eb && start) begin
        for (int i = 0; i < 4; i++) exp_q.push_back({d_in[i], l_in[i], 2'(i)});
        exp_vv  = 1'b0;
        pend_vl = vote_of(l_in);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [DW-1:0] a0, a1, a2, a3,
                            input logic [LW-1:0] b0, b1, b2, b3);
    d_in[0] = a0; d_in[1] = a1; d_in[2] = a2; d_in[3] = a3;
    l_in[0] = b0; l_in[1] = b1; l_in[2] = b2; l_in[3] = b3;
  endtask

  task automatic chk_beat(input string name, input logic [DW-1:0] d,
                          input logic [LW-1:0] l, input logic [1:0] i);
    chk({name, "_v"}, 64'(out_valid), 64'd1);
    chk({name, "_d"}, 64'(OUT_DATA),  64'(d));
    chk({name, "_l"}, 64'(OUT_LABEL), 64'(l));
    chk({name, "_i"}, 64'(OUT_IDX),   64'(i));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    set_inputs('0, '0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // basic drain
    tick();
    set_inputs(5, 17, 230, 9000, 1, 2, 1, 3);
    start = 1'b1;
    tick(); start = 1'b0;                 // n+1
    chk_beat("basic0", 5, 1, 0);
    tick(); chk_beat("basic1", 17, 2, 1);
    tick(); chk_beat("basic2", 230, 1, 2);
    tick(); chk_beat("basic3", 9000, 3, 3);
    chk("basic_last", 64'(OUT_LAST), 64'd1);
    repeat (DLAT) tick();
    chk("basic_done", 64'(done), 64'd1);
`ifdef KNN_VOTE_EN
    chk("basic_vote", 64'(VOTE_LABEL), 64'd1);
    chk("basic_vote_v", 64'(VOTE_VALID), 64'd1);
`endif
    tick();
    chk("basic_idle", 64'(busy), 64'd0);

    // back-pressure on cycles n+2..n+6
    set_inputs(5, 17, 230, 9000, 1, 2, 1, 3);
    start = 1'b1;
    tick(); start = 1'b0;                 // n+1
    chk_beat("bp0", 5, 1, 0);
    tick(); out_ready = 1'b0;             // n+2
    chk_beat("bp1_hold_a", 17, 2, 1);
    repeat (4) tick();                    // n+6
    chk_beat("bp1_hold_b", 17, 2, 1);
    tick(); out_ready = 1'b1;             // n+7
    chk_beat("bp1_xfer", 17, 2, 1);
    tick(); chk_beat("bp2", 230, 1, 2);
    tick(); chk_beat("bp3", 9000, 3, 3);
    repeat (DLAT) tick();                 // n+10 without vote
    chk("bp_done", 64'(done), 64'd1);
    tick();

    // start while busy is ignored
    set_inputs(11, 22, 33, 44, 2, 3, 3, 2);
    start = 1'b1;
    tick(); start = 1'b0;                 // n+1
    chk_beat("busy0", 11, 2, 0);
    tick();                               // n+2
    set_inputs(99, 98, 97, 96, 7, 7, 7, 7);
    start = 1'b1;
    chk_beat("busy1", 22, 3, 1);
    tick(); start = 1'b0;                 // n+3
    chk_beat("busy2", 33, 3, 2);
    tick(); chk_beat("busy3", 44, 2, 3);
    repeat (DLAT) tick();
    chk("busy_done", 64'(done), 64'd1);
`ifdef KNN_VOTE_EN
    chk("tie_vote", 64'(VOTE_LABEL), 64'd2);
`endif
    tick();

    // reset mid-drain, then an immediate new start
    set_inputs(100, 200, 300, 400, 1, 1, 1, 1);
    start = 1'b1;
    tick(); start = 1'b0;                 // n+1
    tick();                               // n+2
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy",  64'(busy),      64'd0);
    chk("mid_rst_data",  64'(OUT_DATA),  64'd0);
    chk("mid_rst_idx",   64'(OUT_IDX),   64'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    set_inputs(7, 8, 9, 10, 5, 5, 6, 6);
    start = 1'b1;
    tick(); start = 1'b0;
    chk_beat("post_rst0", 7, 5, 0);
    repeat (3) tick();
    chk_beat("post_rst3", 10, 6, 3);
    repeat (DLAT) tick();
    chk("post_rst_done", 64'(done), 64'd1);
    tick();

    // all-ones sentinel distances pass through unchanged
    set_inputs(KNN_SENTINEL, KNN_SENTINEL, KNN_SENTINEL, KNN_SENTINEL, 4, 4, 4, 4);
    start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_beat("sentinel", 32'hFFFF_FFFF, 4, 2'(i));
      tick();
    end
    repeat (DLAT - 1) tick();
    chk("sentinel_done", 64'(done), 64'd1);

    repeat (3) tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/knn_result_reader.md
KNN_RESULT_READER -- requirements
Module: knn_result_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one distance word.
REQ-002 SHALL have parameter LABEL_W, default 8, width of one class label.
REQ-003 SHALL have parameter K, default 4, number of sorted entries read per result; fixed at 4 in this revision.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to snapshot and drain the sorter result.
REQ-007 SHALL have ports DATA0_IN..DATA3_IN  input  DATA_W each  sorted distances from the sorter, index 0 nearest.
REQ-008 SHALL have ports LABEL0_IN..LABEL3_IN  input  LABEL_W each  labels paired with DATA0_IN..DATA3_IN.
REQ-009 SHALL have port out_valid  output  1  current beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-011 SHALL have port OUT_DATA  output  DATA_W  distance of the current beat.
REQ-012 SHALL have port OUT_LABEL  output  LABEL_W  label of the current beat.
REQ-013 SHALL have port OUT_IDX  output  2  rank of the current beat, 0..K-1.
REQ-014 SHALL have port OUT_LAST  output  1  high on the beat with OUT_IDX==K-1.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse when the drain completes.

Function
REQ-017 SHALL implement states IDLE, SEND, VOTE (only with KNN_VOTE_EN), and DONE.
REQ-018 SHALL, in IDLE with start=1, register all K DATA/LABEL inputs into a snapshot and go to SEND.
REQ-019 SHALL ignore start outside IDLE; the snapshot SHALL stay unchanged until the next accepted start.
REQ-020 SHALL hold out_valid=1 throughout SEND, with OUT_DATA/OUT_LABEL taken from the snapshot entry OUT_IDX.
REQ-021 SHALL treat a beat as transferred only on a cycle with out_valid and out_ready both high, then increment OUT_IDX.
REQ-022 SHALL keep all out_* outputs stable while out_valid=1 and out_ready=0, with no timeout.
REQ-023 SHALL leave SEND after the OUT_LAST transfer: to VOTE if KNN_VOTE_EN, else to DONE.
REQ-024 SHALL stay in DONE exactly one cycle with done=1, then return to IDLE.
REQ-025 SHALL hold out_valid=0 outside SEND, with OUT_IDX=0 and OUT_LAST=0.
REQ-026 SHALL give this latency with out_ready held at 1 and start in cycle n:
  - beats in cycles n+1..n+4;
  - done in cycle n+5 without KNN_VOTE_EN, n+9 with it.
REQ-027 SHALL send all K entries unchanged, including sentinel distances of all-ones.

Reset
REQ-028 SHALL, on rst low, immediately clear the following, independent of clk:
  - state to IDLE;
  - out_valid, OUT_LAST, busy and done to 0;
  - OUT_IDX and the snapshot to 0;
  - VOTE_LABEL and VOTE_VALID to 0.
REQ-029 SHALL, on reset during SEND or VOTE, abandon the partial drain with no done pulse.
REQ-030 SHALL accept start on the first rising clk edge after rst deasserts.

Configuration
REQ-031 SHALL, when macro KNN_VOTE_EN is defined, add the following:
  - outputs VOTE_LABEL (LABEL_W) and VOTE_VALID (1);
  - a VOTE state of K cycles; in cycle j, count the snapshot labels equal to label j;
  - keep candidate j only if its count is strictly greater than the best so far, so ties go to the nearest entry.
REQ-032 SHALL register VOTE_LABEL and set VOTE_VALID=1 in the DONE cycle, then hold both until the next accepted start, which clears VOTE_VALID.
REQ-033 SHALL, without KNN_VOTE_EN, omit the VOTE state, the vote ports and the counting logic entirely.

Structure
REQ-034 SHALL place the state encoding, the K constant and the all-ones sentinel constant in shared package knn_pkg.
REQ-035 SHALL implement the vote counter as sub-module knn_vote_cnt: one label plus K snapshot labels in, match count out, combinational.

Verification
REQ-036 SHALL cover a basic drain:
  - stimulus: DATA 5,17,230,9000, labels 1,2,1,3, start with out_ready=1;
  - response: beats 5/1/0, 17/2/1, 230/1/2, 9000/3/3 (data/label/idx) in cycles n+1..n+4, OUT_LAST on idx 3, done at n+5.
REQ-037 SHALL cover back-pressure: out_ready=0 for cycles n+2..n+6 -> the idx 1 beat (17) holds stable and done shifts by 5 cycles.
REQ-038 SHALL cover start while busy: a second start at n+2 with different inputs -> ignored, and the original values complete.
REQ-039 SHALL cover reset mid-drain: rst low at n+2 -> out_valid=0 and busy=0 immediately, no done, and the next start drains the new snapshot.
REQ-040 SHALL cover the vote (KNN_VOTE_EN):
  - labels 1,2,1,3 -> VOTE_LABEL=1 at done;
  - labels 2,3,3,2 -> the 2:2 tie resolves to VOTE_LABEL=2.
REQ-041 SHALL cover the sentinel: all DATA inputs 0xFFFFFFFF -> four beats of 0xFFFFFFFF are sent, then done.
